// File: rtl/hqm_AW_pkg.sv
// hqm_AW_pkg: shared FSM type and width helper for the assertion RAM arbiter
package hqm_AW_pkg;
  typedef enum logic {INIT, RUN} hqm_assertion_ram_arb_state_t;
  function automatic int AW_logb2(input int x);
    int r;
    r = 0;
    for (int v = x; v > 1; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/hqm_assertion_rr_arb.sv
// hqm_assertion_rr_arb: combinational round-robin pick, highest priority at ptr
module hqm_assertion_rr_arb import hqm_AW_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IWIDTH = AW_logb2(NUM_REQ-1)+1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IWIDTH-1:0]  ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IWIDTH-1:0]  gnt_id
);
  logic [IWIDTH-1:0] idx;
  logic found;
  // scan ptr, ptr+1, ... with wrap; the first active requester wins
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IWIDTH'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id = idx;
      end
    end
  end
endmodule

// File: rtl/hqm_assertion_ram_arb.sv
// hqm_assertion_ram_arb: round-robin arbiter and zero-init sweep for a shared 1R1W assertion RAM
// The init sweep is built only when HQM_ASSERTION_RAM_ARB_INIT_EN is defined.
module hqm_assertion_ram_arb import hqm_AW_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH = 8,
  parameter int DWIDTH = 16,
  parameter int AWIDTH = AW_logb2(DEPTH-1)+1,
  parameter int IWIDTH = AW_logb2(NUM_REQ-1)+1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]        req_v,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                     rsp_v,
  output logic [IWIDTH-1:0]         rsp_id,
  output logic [DWIDTH-1:0]         rsp_data,
  output logic                     init_done,
  output logic                     err_unexp_rdata,
  output logic                     ram_we,
  output logic                     ram_re,
  output logic [AWIDTH-1:0]         ram_waddr,
  output logic [AWIDTH-1:0]         ram_raddr,
  output logic [DWIDTH-1:0]         ram_wdata,
  input  logic [DWIDTH-1:0]         ram_rdata,
  input  logic                     ram_rdata_v
);
  hqm_assertion_ram_arb_state_t state;
  logic [IWIDTH-1:0] rr_ptr, gnt_id, id1, id2;
  logic [NUM_REQ-1:0] gnt;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;
  logic sel_we, any_gnt, rd_v1, rd_v2;
`ifdef HQM_ASSERTION_RAM_ARB_INIT_EN
  localparam logic [AWIDTH:0] INIT_END = DEPTH[AWIDTH:0];
  logic [AWIDTH:0] init_cnt;
`endif

  hqm_assertion_rr_arb #(.NUM_REQ(NUM_REQ), .IWIDTH(IWIDTH)) u_rr (
    .req(req_v),
    .ptr(rr_ptr),
    .gnt(gnt),
    .gnt_id(gnt_id)
  );

  assign req_ready = (state == RUN) ? gnt : '0;
  assign any_gnt = |req_ready;
  assign sel_we = req_we[gnt_id];
  assign sel_addr = req_addr[int'(gnt_id)*AWIDTH +: AWIDTH];
  assign sel_wdata = req_wdata[int'(gnt_id)*DWIDTH +: DWIDTH];
  assign init_done = state == RUN;
  assign rsp_v = ram_rdata_v;
  assign rsp_data = ram_rdata;
  assign rsp_id = id2;

  // FSM, round-robin pointer, init sweep and registered RAM command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef HQM_ASSERTION_RAM_ARB_INIT_EN
      state <= INIT;
      init_cnt <= '0;
`else
      state <= RUN;
`endif
      rr_ptr <= '0;
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      ram_waddr <= '0;
      ram_raddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= any_gnt & sel_we;
      ram_re <= any_gnt & ~sel_we;
      if (any_gnt && sel_we) begin
        ram_waddr <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      if (any_gnt && !sel_we) ram_raddr <= sel_addr;
      if (any_gnt) rr_ptr <= (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + 1'b1;
`ifdef HQM_ASSERTION_RAM_ARB_INIT_EN
      if (state == INIT) begin
        ram_we <= init_cnt != INIT_END;
        ram_waddr <= init_cnt[AWIDTH-1:0];
        ram_wdata <= '0;
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == INIT_END) state <= RUN;
      end
`endif
    end
  end

  // read id pipeline aligned with RAM read return; sticky flag for stray read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      id1 <= '0;
      id2 <= '0;
      err_unexp_rdata <= 1'b0;
    end else begin
      rd_v1 <= any_gnt & ~sel_we;
      id1 <= gnt_id;
      rd_v2 <= rd_v1;
      id2 <= id1;
      err_unexp_rdata <= err_unexp_rdata | (ram_rdata_v & ~rd_v2);
    end
  end
endmodule

// File: tb/tb_hqm_assertion_ram_arb.sv
// tb_hqm_assertion_ram_arb: directed bench with RAM model and response scoreboard
module tb_hqm_assertion_ram_arb;
  localparam int N = 4, D = 8, DW = 16, AW = 3, IW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_v = '0, req_we = '0, req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic rsp_v, init_done, err_unexp_rdata, ram_we, ram_re, ram_rdata_v;
  logic [IW-1:0] rsp_id;
  logic [DW-1:0] rsp_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic rv_q, inj_v = 1'b0, load = 1'b0;
  logic [DW-1:0] mem [D];
  logic [DW-1:0] model [D];
  typedef struct {int id; logic [DW-1:0] data; int cyc;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0;

  hqm_assertion_ram_arb #(.NUM_REQ(N), .DEPTH(D), .DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_v(req_v), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_v(rsp_v), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .init_done(init_done), .err_unexp_rdata(err_unexp_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_rdata_v(ram_rdata_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) for (int i = 0; i < D; i++) mem[i] <= DW'(32'hA5A0 + i);
    else if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= 1'b0;
      ram_rdata <= '0;
    end else begin
      rv_q <= ram_re;
      if (ram_re) ram_rdata <= mem[ram_raddr];
    end
  end

  assign ram_rdata_v = rv_q | inj_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rsp_v && !inj_v) begin
      if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_v), 0);
      else begin
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), e.id);
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_cycle", cyc, e.cyc);
      end
    end else if (!inj_v && sb.size() > 0 && sb[0].cyc <= cyc) begin
      check("rsp_missing", 32'(rsp_v), 1);
      void'(sb.pop_front());
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input int a, input int d);
    req_v[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = AW'(a);
    req_wdata[i*DW +: DW] = DW'(d);
  endtask

  task automatic clear_req();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic grant(input string tag, input logic [N-1:0] exp);
    logic [AW-1:0] a;
    #1;
    check(tag, 32'(req_ready), 32'(exp));
    for (int i = 0; i < N; i++) begin
      if (exp[i]) begin
        a = req_addr[i*AW +: AW];
        if (req_we[i]) model[a] = req_wdata[i*DW +: DW];
        else sb.push_back('{i, model[a], cyc + 2});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) model[i] = DW'(32'hA5A0 + i);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp_v", 32'(rsp_v), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_err", 32'(err_unexp_rdata), 0);
    check("rst_ram_cmd", 32'({ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata}), 0);
`ifdef HQM_ASSERTION_RAM_ARB_INIT_EN
    check("rst_init_done", 32'(init_done), 0);
`else
    check("rst_init_done", 32'(init_done), 1);
`endif
    rst_n = 1'b1;
    cyc = 0;
`ifdef HQM_ASSERTION_RAM_ARB_INIT_EN
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, i, 0);
    for (int k = 1; k <= D; k++) begin
      tick();
      #1;
      check("init_we", 32'(ram_we), 1);
      check("init_addr", 32'(ram_waddr), k - 1);
      check("init_wdata", 32'(ram_wdata), 0);
      check("init_done_low", 32'(init_done), 0);
      check("init_ready", 32'(req_ready), 0);
    end
    clear_req();
    for (int i = 0; i < D; i++) model[i] = '0;
    tick();
    check("init_done_cycle", 32'(init_done), 1);
    check("init_we_end", 32'(ram_we), 0);
`endif
    for (int a = 0; a < D; a++) begin
      set_req(3, 1'b1, 1'b0, a, 0);
      grant("sweep_gnt", 4'b1000);
      tick();
    end
    clear_req();
    set_req(3, 1'b1, 1'b0, 1, 0);
    grant("sparse_3", 4'b1000);
    tick();
    clear_req();
    set_req(0, 1'b1, 1'b0, 6, 0);
    set_req(2, 1'b1, 1'b0, 7, 0);
    grant("sparse_0", 4'b0001);
    tick();
    grant("sparse_2", 4'b0100);
    tick();
    clear_req();
    set_req(3, 1'b1, 1'b0, 3, 0);
    grant("sparse_wrap", 4'b1000);
    tick();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, i, 0);
    grant("rr_0", 4'b0001); tick();
    grant("rr_1", 4'b0010); tick();
    grant("rr_2", 4'b0100); tick();
    grant("rr_3", 4'b1000); tick();
    grant("rr_0b", 4'b0001); tick();
    grant("rr_1b", 4'b0010); tick();
    clear_req();
    repeat (3) tick();
    set_req(1, 1'b1, 1'b1, 5, 16'hBEEF);
    grant("wr_gnt", 4'b0010);
    tick();
    check("wr_ram_we", 32'(ram_we), 1);
    check("wr_ram_waddr", 32'(ram_waddr), 5);
    check("wr_ram_wdata", 32'(ram_wdata), 32'hBEEF);
    clear_req();
    set_req(2, 1'b1, 1'b0, 5, 0);
    grant("rd_gnt", 4'b0100);
    tick();
    check("rd_ram_re", 32'(ram_re), 1);
    check("rd_ram_raddr", 32'(ram_raddr), 5);
    check("rd_ram_we", 32'(ram_we), 0);
    clear_req();
    repeat (3) tick();
    check("err_quiet", 32'(err_unexp_rdata), 0);
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    check("err_set", 32'(err_unexp_rdata), 1);
    repeat (3) tick();
    check("err_sticky", 32'(err_unexp_rdata), 1);
    set_req(0, 1'b1, 1'b0, 2, 0);
    grant("mf_gnt", 4'b0001);
    tick();
    clear_req();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mf_ram_re", 32'(ram_re), 0);
    check("mf_err_clr", 32'(err_unexp_rdata), 0);
    tick();
    check("mf_rsp_v", 32'(rsp_v), 0);
    rst_n = 1'b1;
    cyc = 0;
    tick();
`ifdef HQM_ASSERTION_RAM_ARB_INIT_EN
    check("mf_init_we", 32'(ram_we), 1);
    check("mf_init_addr", 32'(ram_waddr), 0);
    check("mf_init_done", 32'(init_done), 0);
    repeat (D) tick();
    check("mf_init_done_end", 32'(init_done), 1);
`else
    check("mf_init_done", 32'(init_done), 1);
    tick();
`endif
    check("mf_rsp_v2", 32'(rsp_v), 0);
    check("mf_err", 32'(err_unexp_rdata), 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
